// File: rtl/cfu_act_fifo_pkg.sv
// Shared opcodes, response codes and status-word layout for the activation FIFO.
package cfu_act_pkg;

   localparam logic [6:0]  OP_PUSH        = 7'd1;
   localparam logic [6:0]  OP_CLEAR       = 7'd2;
   localparam logic [6:0]  OP_STATUS      = 7'd3;

   localparam logic [31:0] RSP_OK         = 32'd0;
   localparam logic [31:0] RSP_FULL       = 32'd1;
   localparam logic [31:0] RSP_BADOP      = 32'hFFFF_FFFF;

   localparam int unsigned STATUS_OVF_BIT = 31;

   // Status word: overflow flag in the top bit, occupancy in the low half.
   function automatic logic [31:0] status_word(input logic ovf, input logic [15:0] cnt);
      logic [31:0] w;
      w                 = '0;
      w[STATUS_OVF_BIT] = ovf;
      w[15:0]           = cnt;
      return w;
   endfunction

endpackage

// File: rtl/cfu_act_fifo_core.sv
// Circular storage with read/write pointers and occupancy count.
// Read data is first-word fall-through from the head entry.
module sync_fifo_core
   import cfu_act_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

   // Pointer/count update; clear wins after any same-cycle pop has been served.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(wr_en) - CW'(rd_en);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (wr_en && !clear) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/cfu_act_fifo.sv
// CFU-facing activation FIFO: command decode, registered response,
// sticky overflow flag, and a valid/ready stream toward conv1d.
module cfu_act_fifo
   import cfu_act_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [6:0]       cmd_funct7,
   input  logic [31:0]      cmd_in0,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);

   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        ovf_q, ovf_d;
   logic        cmd_fire;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_clear;
   logic        fifo_full;
   logic        fifo_empty;

   assign cmd_ready = ~rsp_valid_q;
   assign cmd_fire  = cmd_valid & cmd_ready;
   assign out_valid = ~fifo_empty;
   assign fifo_pop  = out_valid & out_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

   sync_fifo_core #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .clear (fifo_clear),
      .din   (WIDTH'(cmd_in0)),
      .dout  (out_data),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Command decode and next response/overflow state.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      ovf_d       = ovf_q;
      fifo_push   = 1'b0;
      fifo_clear  = 1'b0;
      if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
      if (cmd_fire) begin
         rsp_valid_d = 1'b1;
         case (cmd_funct7)
            OP_PUSH: begin
               if (fifo_full) begin
                  ovf_d      = 1'b1;
                  rsp_data_d = RSP_FULL;
               end else begin
                  fifo_push  = 1'b1;
                  rsp_data_d = RSP_OK;
               end
            end
            OP_CLEAR: begin
               fifo_clear = 1'b1;
               ovf_d      = 1'b0;
               rsp_data_d = 32'(count) - 32'(fifo_pop);
            end
            OP_STATUS: rsp_data_d = status_word(ovf_q, 16'(count));
            default:   rsp_data_d = RSP_BADOP;
         endcase
      end
   end

   // Response and overflow registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         ovf_q       <= ovf_d;
      end
   end

endmodule

// File: doc/cfu_act_fifo.md
Name: cfu_act_fifo

Overview:
Activation staging FIFO between the CFU command handshake and the conv1d compute core. The CPU pushes packed 4×int8 activation words through CFU commands. The block buffers them in a circular store and streams them to conv1d over a valid/ready interface. It also answers CLEAR and STATUS commands so software can flush the buffer and poll occupancy and overflow.

Parameters:
DEPTH, 16, number of 32-bit entries; power of two, minimum 2
WIDTH, 32, data word width (4 packed int8)
CW, $clog2(DEPTH+1), count width (derived; do not override)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  CFU command valid
cmd_ready  out  1  CFU command ready
cmd_funct7  in  7  opcode (function_id[9:3])
cmd_in0  in  32  command operand 0
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted by CPU
rsp_data  out  32  response payload
out_valid  out  1  activation word available to conv1d
out_ready  in  1  conv1d consumes word
out_data  out  WIDTH  head-of-FIFO word
count  out  CW  current occupancy

Behaviour:
- Reset: rsp_valid=0, rsp_data=0, count=0, overflow flag=0, rd/wr pointers=0, out_valid=0. Storage contents undefined. Reset mid-operation drops any pending response and all stored words.
- cmd_ready = ~rsp_valid, so at most one outstanding command. A command is accepted when cmd_valid && cmd_ready.
- The response is registered: rsp_valid rises the cycle after acceptance, and rsp_data is stable while rsp_valid=1. rsp_valid clears the cycle after rsp_valid && rsp_ready.
- Opcodes:
  - OP_PUSH=1: if count<DEPTH at the start of the cycle, write cmd_in0 at wr_ptr, advance wr_ptr, and set rsp_data=0. If full, drop the word, set the sticky overflow flag, and set rsp_data=1.
  - OP_CLEAR=2: set pointers and count to 0 and clear overflow. rsp_data = number of words discarded, which is count minus any same-cycle pop.
  - OP_STATUS=3: rsp_data = {overflow, 15'b0, 16-bit zero-extended count}. Count is sampled before this cycle's pop.
  - Any other opcode: no state change; rsp_data=32'hFFFF_FFFF.
- Downstream interface: out_valid = (count!=0). out_data = mem[rd_ptr] combinationally (first-word fall-through). A pop occurs when out_valid && out_ready and advances rd_ptr.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Simultaneous events:
  - PUSH and pop, not full: both occur; count unchanged.
  - PUSH when full with a same-cycle pop: the push is still rejected (fullness is evaluated at cycle start); count drops by 1.
  - PUSH when empty: the word is visible on out_data the next cycle; no same-cycle bypass.
  - CLEAR and pop: the pop completes (conv1d keeps the word), then everything else is flushed.
- Latency: command to rsp_valid is 1 cycle; PUSH to out_valid is 1 cycle.
- overflow stays set until CLEAR or reset.

Decomposition:
- Package cfu_act_pkg holds:
  - OP_PUSH, OP_CLEAR and OP_STATUS as 7-bit localparams
  - RSP_OK=0, RSP_FULL=1, RSP_BADOP=32'hFFFF_FFFF
  - STATUS_OVF_BIT=31
- One sub-module, sync_fifo_core, holds the storage array, pointers, count and full/empty logic. Its inputs are push, pop, clear, din; its outputs are dout, count, full, empty.
- The top level holds command decode, the response register and the overflow flag.

Test Plan:
- Reset, then STATUS: rsp_data=0x0000_0000, out_valid=0, and rsp_valid rises exactly 1 cycle after acceptance.
- PUSH 0x11223344 with out_ready=0, then STATUS: first response 0, second 0x0000_0001. out_valid=1 and out_data=0x11223344 the cycle after the push.
- Fill all 16 entries, then PUSH 0xDEADBEEF: response 1 and count stays 16. STATUS=0x8000_0010. Draining yields the 16 pushed words in order, never 0xDEADBEEF.
- Wrap-around: push 10 words, pop 10, push 12, pop 12. All data is in order and count returns to 0 (pointers wrapped).
- Push 5 words, then CLEAR with out_ready=1 in the same cycle: the word at the head is consumed, rsp_data=4, count=0, and the overflow flag is clear.
- Opcode 0x7F: rsp_data=0xFFFF_FFFF and count unchanged. Holding rsp_ready=0 for 3 cycles keeps rsp_valid=1 and cmd_ready=0 throughout.
